cbus_sram_responder: RTL and testbench

Cache-bus responder that serves `cbus_req_t` burst reads and writes from an internal word-addressed SRAM array. It sits on the memory side of the cbus, in place of the AXI bridge, and answers ICache line refills (16 × 4-byte read bursts) and DCache write-backs in simulation and FPGA bring-up builds. It replies with one `cbus_resp_t` beat per cycle after a fixed initial latency. An optional compiled-in stall generator stresses initiator back-pressure handling.

---
 rtl/cbus_sram_responder.sv | 180 ++++++++++++++++++
 tb/tb_cbus_sram_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cbus_sram_responder.sv
// Cache-bus SRAM responder: serves cbus burst reads/writes from an internal word array.
// Optional build macro CBUS_SRAM_STALL_EN adds an LFSR-driven beat stall generator.

package cbus_pkg;

    typedef enum logic [2:0] {
        MLEN1  = 3'd0,
        MLEN2  = 3'd1,
        MLEN4  = 3'd2,
        MLEN8  = 3'd3,
        MLEN16 = 3'd4
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 65536,
    parameter int unsigned INIT_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AB    = $clog2(MEM_BYTES);
    localparam int AW    = AB - 2;
    localparam int WORDS = MEM_BYTES / 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            is_wr;
    logic [AW-1:0]   base_idx;
    logic [AW-1:0]   idx;
    logic [3:0]      k;
    logic [3:0]      last_k;
    logic [3:0]      lat;
    logic            stall;
    logic            beat_ok;
    logic [31:0]     mem [WORDS];

    // Word index wraps naturally through the AW-bit adder; upper address bits alias.
    assign idx = base_idx + AW'(k);

`ifdef CBUS_SRAM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign stall = lfsr[0];

    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr};
`else
    assign stall = 1'b0;

    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr, LFSR_SEED};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            base_idx <= '0;
            k        <= 4'd0;
            last_k   <= 4'd0;
            lat      <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (creq.valid) begin
                        is_wr    <= creq.is_write;
                        base_idx <= creq.addr[AB-1:2];
                        k        <= 4'd0;
                        lat      <= 4'(INIT_LATENCY);
                        case (creq.len)
                            MLEN1:   last_k <= 4'd0;
                            MLEN2:   last_k <= 4'd1;
                            MLEN4:   last_k <= 4'd3;
                            MLEN8:   last_k <= 4'd7;
                            default: last_k <= 4'd15;
                        endcase
                    end
                end
                WAIT: begin
                    lat <= lat - 4'd1;
                end
                BURST: begin
                    if (beat_ok) begin
                        k <= k + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response is purely combinational so an async reset or a dropped valid silences it at once.
    always_comb begin
        state_nxt = state;
        beat_ok   = 1'b0;
        cresp     = '0;
        case (state)
            IDLE: begin
                if (creq.valid) begin
                    state_nxt = (INIT_LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_nxt = IDLE;
                end else if (lat <= 4'd1) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_nxt = IDLE;
                end else if (!stall) begin
                    beat_ok     = 1'b1;
                    cresp.ready = 1'b1;
                    cresp.last  = (k == last_k);
                    cresp.data  = is_wr ? 32'h0 : mem[idx];
                    if (k == last_k) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SRAM array has no reset; byte lanes follow the strobe regardless of size.
    always_ff @(posedge clk) begin
        if (beat_ok && is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder; builds with or without CBUS_SRAM_STALL_EN.
// Expected beats are hand-computed; stall timing comes from a reference LFSR model.

module tb_cbus_sram_responder;
    import cbus_pkg::*;

    localparam int LAT   = 2;
    localparam int MEMB  = 65536;
    localparam int WORDS = MEMB / 4;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wdata [16];
    logic [3:0]  wstrb [16];
    logic [31:0] rexp  [16];
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    cbus_sram_responder #(
        .MEM_BYTES   (MEMB),
        .INIT_LATENCY(LAT),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .creq (creq),
        .cresp(cresp)
    );

`ifdef CBUS_SRAM_STALL_EN
    // Reference stall source: Galois LFSR, taps 16,14,13,11, free-running from reset.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
`else
    initial lfsr_m = 16'h0000;
`endif

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: full burst, mode 1: drop valid when stop_at beats are done, mode 2: assert reset then
    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input cbus_len_t len,
                                  input int n, input int mode, input int stop_at, input string tag);
        int   b = 0;
        int   c = 0;
        logic done = 1'b0;
        logic exp_rdy;
        @(negedge clk);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = addr;
        creq.len      = len;
        creq.size     = 3'd2;
        creq.data     = wdata[0];
        creq.strobe   = wr ? wstrb[0] : 4'h0;
        #1 check_output({tag, "/accept_ready"}, 32'(cresp.ready), 32'd0);
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            if (mode == 1 && b == stop_at) begin
                creq.valid = 1'b0;
                #1;
                check_output({tag, "/abort_ready"}, 32'(cresp.ready), 32'd0);
                check_output({tag, "/abort_data"}, cresp.data, 32'd0);
                done = 1'b1;
            end else begin
                creq.data   = wdata[b];
                creq.strobe = wr ? wstrb[b] : 4'h0;
                #1;
                exp_rdy = (c >= 1 + LAT) && !lfsr_m[0];
                if (mode == 2 && b == stop_at) begin
                    #1 reset = 1'b1;
                    #1;
                    check_output({tag, "/rst_ready"}, 32'(cresp.ready), 32'd0);
                    check_output({tag, "/rst_last"}, 32'(cresp.last), 32'd0);
                    check_output({tag, "/rst_data"}, cresp.data, 32'd0);
                    creq.valid = 1'b0;
                    repeat (2) @(negedge clk);
                    reset = 1'b0;
                    done  = 1'b1;
                end else begin
                    check_output($sformatf("%s/ready_c%0d", tag, c), 32'(cresp.ready), 32'(exp_rdy));
                    if (exp_rdy) begin
                        check_output($sformatf("%s/last_b%0d", tag, b), 32'(cresp.last), 32'(b == n - 1));
                        check_output($sformatf("%s/data_b%0d", tag, b), cresp.data, wr ? 32'd0 : rexp[b]);
                        if (b == n - 1) done = 1'b1;
                        b++;
                    end else begin
                        check_output($sformatf("%s/last_c%0d", tag, c), 32'(cresp.last), 32'd0);
                        check_output($sformatf("%s/zero_c%0d", tag, c), cresp.data, 32'd0);
                    end
                end
            end
        end
        check_output({tag, "/completed"}, 32'(done), 32'd1);
        if (mode == 0) begin
            @(negedge clk);
            creq.valid = 1'b0;
            #1 check_output({tag, "/post_idle"}, 32'(cresp.ready), 32'd0);
        end
    endtask

    task automatic preload(input int base);
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 32'hA000_0000 + 32'(base + i);
            wstrb[i] = 4'hF;
        end
        apply_stimulus(1'b1, 32'(base * 4), MLEN16, 16, 0, 0, "preload");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        creq  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_ready", 32'(cresp.ready), 32'd0);
        check_output("reset_last", 32'(cresp.last), 32'd0);
        check_output("reset_data", cresp.data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int base = 0; base < 80; base += 16) preload(base);
        preload(WORDS - 16);

        $display("[TB] MLEN16 read at 0x1FC0_0040");
        for (int i = 0; i < 16; i++) rexp[i] = 32'hA000_0010 + 32'(i);
        apply_stimulus(1'b0, 32'h1FC0_0040, MLEN16, 16, 0, 0, "rd16");

        $display("[TB] MLEN4 write with partial strobe, then read back");
        wdata[0] = 32'h1111_1111; wstrb[0] = 4'hF;
        wdata[1] = 32'h2222_2222; wstrb[1] = 4'b0011;
        wdata[2] = 32'h3333_3333; wstrb[2] = 4'hF;
        wdata[3] = 32'h4444_4444; wstrb[3] = 4'hF;
        apply_stimulus(1'b1, 32'h0000_0100, MLEN4, 4, 0, 0, "wr4");
        rexp[0] = 32'h1111_1111;
        rexp[1] = 32'hA000_2222;
        rexp[2] = 32'h3333_3333;
        rexp[3] = 32'h4444_4444;
        apply_stimulus(1'b0, 32'h0000_0100, MLEN4, 4, 0, 0, "rb4");

        $display("[TB] abort a 16-beat write after 3 beats");
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 32'hBEEF_0000 + 32'(i);
            wstrb[i] = 4'hF;
        end
        apply_stimulus(1'b1, 32'h0000_0080, MLEN16, 16, 1, 3, "abort");
        rexp[0] = 32'hBEEF_0000;
        apply_stimulus(1'b0, 32'h0000_0080, MLEN1, 1, 0, 0, "rd1");
        for (int i = 0; i < 16; i++) rexp[i] = (i < 3) ? 32'hBEEF_0000 + 32'(i) : 32'hA000_0020 + 32'(i);
        apply_stimulus(1'b0, 32'h0000_0080, MLEN16, 16, 0, 0, "rb_abort");

        $display("[TB] wrap and alias read");
        rexp[0] = 32'hA000_3FFE;
        rexp[1] = 32'hA000_3FFF;
        rexp[2] = 32'hA000_0000;
        rexp[3] = 32'hA000_0001;
        apply_stimulus(1'b0, 32'h8000_FFF8, MLEN4, 4, 0, 0, "wrap");

        $display("[TB] reset during beat 5 of a write");
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 32'hC0DE_0000 + 32'(i);
            wstrb[i] = 4'hF;
        end
        apply_stimulus(1'b1, 32'h0000_00C0, MLEN16, 16, 2, 5, "rst");
        for (int i = 0; i < 16; i++) rexp[i] = (i < 5) ? 32'hC0DE_0000 + 32'(i) : 32'hA000_0030 + 32'(i);
        apply_stimulus(1'b0, 32'h0000_00C0, MLEN16, 16, 0, 0, "rb_rst");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
